ysyx_25010008_mem_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer for the single shared memory port.
//  M0 is the fetch path (IFU) and M1 is the load/store path (LSU).
//  The block grants one requester per transaction using round-robin on ties, and latches the request.
//  It drives the slave handshake, waits for the response, and returns data and an error flag to the granted requester.
//  A watchdog ends stalled transactions with an error response.

---
 rtl/ysyx_25010008_mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ysyx_25010008_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25010008_mem_arbiter.sv
// Two-requester arbiter and sequencer for the shared memory port.
// M0 is the fetch path and M1 is the load/store path. Ties go round-robin.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// A watchdog turns a stalled WAIT into an error response.
module ysyx_25010008_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    // requester 0 (fetch)
    input  logic            m0_req_valid,
    output logic            m0_req_ready,
    input  logic [AW-1:0]   m0_addr,
    input  logic            m0_wen,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wmask,
    output logic            m0_resp_valid,
    input  logic            m0_resp_ready,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,
    // requester 1 (load/store)
    input  logic            m1_req_valid,
    output logic            m1_req_ready,
    input  logic [AW-1:0]   m1_addr,
    input  logic            m1_wen,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wmask,
    output logic            m1_resp_valid,
    input  logic            m1_resp_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,
    // shared memory port
    output logic            s_req_valid,
    input  logic            s_req_ready,
    output logic [AW-1:0]   s_addr,
    output logic            s_wen,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wmask,
    input  logic            s_resp_valid,
    input  logic [DW-1:0]   s_rdata,
    // status
    output logic            busy,
    output logic            grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Timer is wide enough to reach TIMEOUT and saturates instead of wrapping.
    localparam int            TW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    state_t          state;
    state_t          state_next;
    logic            last_grant;
    logic [TW-1:0]   timer;
    logic [DW-1:0]   rdata;
    logic            err;

    logic            any_valid;
    logic            win;
    logic            accept;
    logic            timeout_hit;
    logic            resp_hs;

    // Winner selection and per-cycle handshake conditions.
    always_comb begin
        any_valid   = m0_req_valid | m1_req_valid;
        // Both valid: the requester that did not win last time goes next.
        win         = (m0_req_valid && m1_req_valid) ? ~last_grant : m1_req_valid;
        // Gated by rst so no handshake is advertised in a cycle that reset discards.
        accept      = rst && (state == S_IDLE) && any_valid;
        timeout_hit = (TIMEOUT != 0) && (timer == TIMER_LAST);
        resp_hs     = (state == S_RESP) && (grant ? m1_resp_ready : m0_resp_ready);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of block ordering.
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned
        // and no latch is inferred.
        state_next = state;
        case (state)
            S_IDLE:  if (any_valid)                    state_next = S_ISSUE;
            S_ISSUE: if (s_req_ready)                  state_next = S_WAIT;
            S_WAIT:  if (s_resp_valid || timeout_hit)  state_next = S_RESP;
            S_RESP:  if (resp_hs)                      state_next = S_IDLE;
            default:                                   state_next = S_IDLE;
        endcase
    end

    // Request latch, watchdog timer, response capture and round-robin history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            timer      <= '0;
            rdata      <= '0;
            err        <= 1'b0;
            s_addr     <= '0;
            s_wen      <= 1'b0;
            s_wdata    <= '0;
            s_wmask    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant   <= win;
                        s_addr  <= win ? m1_addr  : m0_addr;
                        s_wen   <= win ? m1_wen   : m0_wen;
                        s_wdata <= win ? m1_wdata : m0_wdata;
                        s_wmask <= win ? m1_wmask : m0_wmask;
                    end
                end
                S_ISSUE: begin
                    if (s_req_ready) timer <= '0;
                end
                S_WAIT: begin
                    if (timer != TIMER_MAX) timer <= timer + 1'b1;
                    // A real response beats a watchdog expiry in the same cycle.
                    if (s_resp_valid) begin
                        rdata <= s_rdata;
                        err   <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_hs) last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

    assign m0_req_ready  = accept & ~win;
    assign m1_req_ready  = accept &  win;
    assign s_req_valid   = (state == S_ISSUE);
    assign m0_resp_valid = (state == S_RESP) & ~grant;
    assign m1_resp_valid = (state == S_RESP) &  grant;
    assign m0_rdata      = rdata;
    assign m1_rdata      = rdata;
    assign m0_err        = err;
    assign m1_err        = err;
    assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_ysyx_25010008_mem_arbiter.sv
// Self-checking bench for ysyx_25010008_mem_arbiter: directed scenarios
// followed by randomized transactions against a transaction-level model.
module tb_ysyx_25010008_mem_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_wen, m0_resp_valid, m0_resp_ready, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        s_req_valid, s_req_ready, s_wen, s_resp_valid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wmask;
    logic        busy, grant;

    ysyx_25010008_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
        .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
        .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid), .s_rdata(s_rdata),
        .busy(busy), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: pending requests per requester and the
    // requester most recently served.
    bit          pend   [2];
    logic [31:0] p_addr [2];
    logic        p_wen  [2];
    logic [31:0] p_wdata[2];
    logic [3:0]  p_wmask[2];
    int          last_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        m0_req_valid = pend[0]; m0_addr = p_addr[0]; m0_wen = p_wen[0];
        m0_wdata = p_wdata[0];  m0_wmask = p_wmask[0];
        m1_req_valid = pend[1]; m1_addr = p_addr[1]; m1_wen = p_wen[1];
        m1_wdata = p_wdata[1];  m1_wmask = p_wmask[1];
    endtask

    task automatic arm(input int n, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] m);
        pend[n] = 1'b1; p_addr[n] = a; p_wen[n] = w; p_wdata[n] = d; p_wmask[n] = m;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        drive_reqs();
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
        m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 1'b0);
        check("rst_s_req_valid", s_req_valid, 1'b0);
        check("rst_m0_resp_valid", m0_resp_valid, 1'b0);
        check("rst_m1_resp_valid", m1_resp_valid, 1'b0);
        check("rst_m0_req_ready", m0_req_ready, 1'b0);
        check("rst_m1_req_ready", m1_req_ready, 1'b0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_s_wen", s_wen, 1'b0);
        check("rst_s_wdata", s_wdata, 32'h0);
        check("rst_s_wmask", {28'h0, s_wmask}, 32'h0);
        check("rst_rdata", m0_rdata, 32'h0);
        check("rst_err", m0_err | m1_err, 1'b0);
        rst = 1'b1;
        last_m = 1;
        @(negedge clk);
    endtask

    // One complete transaction from IDLE. resp_dly is the WAIT cycle on which
    // the slave answers; resp_dly >= TO means it never answers.
    task automatic txn(input int rdy_dly, input int resp_dly,
                       input logic [31:0] sdata, input int cons_dly);
        int          w;
        int          lo;
        logic [31:0] ea, ewd, erd;
        logic        ew, ee;
        logic [3:0]  ewm;
        bit          timed_out;

        // Cycle 0: arbitration.
        drive_reqs();
        #1;
        if (pend[0] && pend[1]) w = (last_m == 0) ? 1 : 0;
        else                    w = pend[1] ? 1 : 0;
        lo = 1 - w;
        check("c0_m0_req_ready", m0_req_ready, (w == 0) ? 1'b1 : 1'b0);
        check("c0_m1_req_ready", m1_req_ready, (w == 1) ? 1'b1 : 1'b0);
        check("c0_busy", busy, 1'b0);
        ea = p_addr[w]; ew = p_wen[w]; ewd = p_wdata[w]; ewm = p_wmask[w];
        @(negedge clk);
        // Winner drops its request and scrambles its fields: the DUT must use its copy.
        pend[w] = 1'b0;
        p_addr[w] = $urandom; p_wdata[w] = $urandom; p_wen[w] = 1'($urandom);
        p_wmask[w] = 4'($urandom);
        drive_reqs();

        // ISSUE: request held stable until the slave accepts.
        for (int i = 0; i <= rdy_dly; i++) begin
            s_req_ready = (i == rdy_dly);
            #1;
            check("iss_s_req_valid", s_req_valid, 1'b1);
            check("iss_s_addr", s_addr, ea);
            check("iss_s_wen", s_wen, ew);
            check("iss_s_wdata", s_wdata, ewd);
            check("iss_s_wmask", {28'h0, s_wmask}, {28'h0, ewm});
            check("iss_grant", grant, w[0]);
            check("iss_busy", busy, 1'b1);
            check("iss_loser_ready", lo ? m1_req_ready : m0_req_ready, 1'b0);
            @(negedge clk);
            s_req_ready = 1'b0;
        end

        // WAIT: response or watchdog.
        timed_out = (resp_dly >= TO);
        for (int k = 0; k < TO; k++) begin
            if (k == resp_dly) begin
                s_resp_valid = 1'b1;
                s_rdata = sdata;
            end
            #1;
            check("wait_s_req_valid", s_req_valid, 1'b0);
            check("wait_resp_valid", m0_resp_valid | m1_resp_valid, 1'b0);
            check("wait_busy", busy, 1'b1);
            check("wait_req_ready", m0_req_ready | m1_req_ready, 1'b0);
            @(negedge clk);
            s_resp_valid = 1'b0;
            s_rdata = $urandom;
            if (k == resp_dly) break;
        end
        erd = timed_out ? 32'h0 : sdata;
        ee  = timed_out;

        // RESP: only the granted requester's ready completes the handshake.
        for (int i = 0; i <= cons_dly; i++) begin
            if (w == 0) begin m0_resp_ready = (i == cons_dly); m1_resp_ready = 1'b1; end
            else        begin m1_resp_ready = (i == cons_dly); m0_resp_ready = 1'b1; end
            // Late slave responses must be ignored outside WAIT.
            s_resp_valid = (i < cons_dly) ? 1'($urandom) : 1'b0;
            s_rdata = $urandom;
            #1;
            check("resp_m0_valid", m0_resp_valid, (w == 0) ? 1'b1 : 1'b0);
            check("resp_m1_valid", m1_resp_valid, (w == 1) ? 1'b1 : 1'b0);
            check("resp_err", w ? m1_err : m0_err, ee);
            if (!ew || ee) check("resp_rdata", w ? m1_rdata : m0_rdata, erd);
            check("resp_loser_ready", lo ? m1_req_ready : m0_req_ready, 1'b0);
            @(negedge clk);
            m0_resp_ready = 1'b0; m1_resp_ready = 1'b0; s_resp_valid = 1'b0;
        end
        last_m = w;
        #1;
        check("post_busy", busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; p_addr[n] = '0; p_wen[n] = 1'b0; p_wdata[n] = '0; p_wmask[n] = '0;
        end
        do_reset(2);

        // Minimum-latency load on M0.
        arm(0, 32'h8000_0000, 1'b0, 32'h0, 4'h0);
        txn(0, 0, 32'hDEAD_BEEF, 0);

        // Simultaneous requests from reset alternate M0, M1, M0, M1.
        do_reset(1);
        arm(0, 32'h8000_0100, 1'b0, 32'h0, 4'h0);
        arm(1, 32'h8000_0200, 1'b0, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            txn(0, 1, 32'hA5A5_0000 + i, 0);
            check("rr_order", {31'h0, last_m[0]}, i % 2);
            if (i < 2) arm(i % 2, 32'h8000_0300 + i, 1'b0, 32'h0, 4'h0);
        end

        // Watchdog: slave never answers an M1 load.
        arm(1, 32'h8000_0400, 1'b0, 32'h0, 4'h0);
        txn(0, TO + 4, 32'h1111_1111, 2);

        // Response on the last WAIT cycle beats the watchdog.
        arm(0, 32'h8000_0500, 1'b0, 32'h0, 4'h0);
        txn(1, TO - 1, 32'hCAFE_F00D, 0);

        // M1 store with slave back-pressure for three cycles.
        arm(1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF);
        txn(3, 1, 32'h0, 0);

        // M0 holds off its response for five cycles while M1 waits.
        arm(0, 32'h8000_0600, 1'b0, 32'h0, 4'h0);
        arm(1, 32'h8000_0700, 1'b1, 32'h0BAD_CAFE, 4'h3);
        txn(0, 2, 32'h7777_8888, 5);
        txn(0, 0, 32'h0, 0);

        // Reset while in WAIT abandons the transaction.
        arm(0, 32'h8000_2000, 1'b0, 32'h0, 4'h0);
        drive_reqs();
        #1 check("rw_c0_ready", m0_req_ready, 1'b1);
        @(negedge clk);
        pend[0] = 1'b0; drive_reqs(); s_req_ready = 1'b1;
        #1 check("rw_issue", s_req_valid, 1'b1);
        @(negedge clk);
        s_req_ready = 1'b0;
        #1 check("rw_wait_busy", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rw_idle", busy, 1'b0);
        check("rw_no_resp", m0_resp_valid | m1_resp_valid, 1'b0);
        check("rw_grant", grant, 1'b0);
        s_resp_valid = 1'b1; s_rdata = 32'h5555_AAAA;
        @(negedge clk);
        s_resp_valid = 1'b0;
        #1;
        check("rw_late_idle", busy, 1'b0);
        check("rw_late_no_resp", m0_resp_valid | m1_resp_valid, 1'b0);
        check("rw_late_rdata", m0_rdata, 32'h0);
        last_m = 1;
        arm(0, 32'h8000_2004, 1'b0, 32'h0, 4'h0);
        txn(0, 0, 32'h600D_600D, 0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            for (int n = 0; n < 2; n++)
                if (!pend[n] && $urandom_range(0, 1) == 1)
                    arm(n, $urandom, 1'($urandom), $urandom, 4'($urandom));
            if (!pend[0] && !pend[1])
                arm($urandom_range(0, 1), $urandom, 1'($urandom), $urandom, 4'($urandom));
            txn($urandom_range(0, 2), $urandom_range(0, TO + 1), $urandom, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
